snake_body: RTL and testbench
=============================

# snake_body

Snake movement and body-shift stage feeding the collision/victory checker. On every accepted move tick it steps the head one grid cell in the committed direction and shifts the 15-slot tail register. It detects food at the new head position, grows the snake and increments the score. Its packed `head_x/head_y/tail_x/tail_y/score` outputs drive `game_over` directly, and it freezes when `game_over` or `victory` comes back high.

## Interface
- `START_X`, default 40: head x after reset (7-bit).
- `START_Y`, default 30: head y after reset (6-bit).
- `clk` in 1: system clock, all logic on the rising edge.
- `reset` in 1: asynchronous, active-low; forces all state to reset values.
- `move_tick` in 1: one-cycle pulse from the speed divider; requests one step.
- `dir_req` in 2: requested direction; 0 up (y−1), 1 down (y+1), 2 left (x−1), 3 right (x+1).
- `dir_valid` in 1: qualifies `dir_req` for one cycle.
- `food_x` in 7, `food_y` in 6: current food cell.
- `game_over` in 1, `victory` in 1: from the collision/victory checker.
- `head_x` out 7, `head_y` out 6: head cell.
- `tail_x` out 105, `tail_y` out 90: segment i at `tail_x[7i+6:7i]` / `tail_y[6i+5:6i]`, i=0..14; i=0 is nearest the head.
- `score` out 4: number of valid tail segments, 0..15.
- `ate` out 1: one-cycle pulse on the step that consumed food; drives the food generator.

## Operation
- FSM states:
  - IDLE (reset state): `move_tick` ignored. The first `dir_valid` loads `dir_cur` and `dir_pend` with `dir_req` and moves to RUN.
  - RUN: steps on `move_tick`.
  - HALT: entered when `game_over` or `victory` is sampled high in RUN. All ticks and requests are ignored; only reset leaves HALT.
- Direction handling in RUN:
  - Accepted `dir_valid` writes `dir_pend`; the last accepted request before a tick wins.
  - A request that reverses `dir_cur` (up↔down, left↔right) is rejected when `score ≥ 1` and accepted when `score == 0`.
  - The reversal check is made against `dir_cur`, not `dir_pend`.
- Step, on `move_tick` in RUN with `game_over`/`victory` low:
  - `dir_cur ← dir_pend`.
  - Next head = head ± 1 on the `dir_pend` axis, modulo 2^7 for x and 2^6 for y. No clamping: frame collision is the checker's job.
  - `tail[0] ← old head`; `tail[i] ← tail[i−1]` for i=1..14. The old `tail[14]` is discarded.
  - If next head == (`food_x`, `food_y`): `score ← score+1`, saturating at 15, and `ate ← 1`. Otherwise `ate ← 0`.
  - Growth needs no extra storage. The shift always happens, so raising `score` exposes the previous last segment as valid.
- Slots at index ≥ `score` hold stale data; consumers must mask them by `score`.
- `dir_valid` and `move_tick` in the same cycle: the tick uses the old `dir_pend`, and the request updates `dir_pend` for the next tick.
- `game_over`/`victory` high in the same cycle as `move_tick`: no step; go to HALT.

## Timing
- All outputs registered. A step on edge N is visible from edge N onward, i.e. one cycle after the `move_tick` cycle.
- `ate` is high for exactly one cycle per food step.
- Reset values:
  - `head_x` = `START_X`, `head_y` = `START_Y`.
  - `tail_x` = 0, `tail_y` = 0, `score` = 0, `ate` = 0.
  - `dir_cur` = `dir_pend` = 3 (right); state IDLE.
- Reset asserted mid-step takes priority immediately; no partial shift survives.
- The checker sees new positions one cycle after the step and flags collisions one cycle later. HALT therefore takes effect before the next `move_tick`, provided the tick period is ≥ 3 cycles. This is a system requirement on the divider.

## Structure
- Shared include `snake_defs.vh`:
  - direction encodings `DIR_UP`/`DIR_DOWN`/`DIR_LEFT`/`DIR_RIGHT`;
  - `X_W` = 7, `Y_W` = 6, `MAX_SEG` = 15;
  - FSM state codes.
- One natural sub-module, `snake_dir_ctrl`: holds `dir_cur`/`dir_pend` and the reversal filter, and outputs `dir_pend`. Shift register, score and FSM stay in `snake_body`.

## Test plan
- Reset, then ticks with no `dir_valid`: head stays at (40, 30), `score` = 0, state IDLE.
- `dir_valid` with right, then 3 ticks: head (43, 30); `tail[0]` = (42, 30), `tail[1]` = (41, 30), `tail[2]` = (40, 30).
- Food at (41, 30), head (40, 30) moving right, tick: head (41, 30), `score` = 1, `ate` pulses 1 cycle, `tail[0]` = (40, 30).
- `score` = 2 moving right, `dir_valid` left, then tick: request rejected, head x+1. With `score` = 0, the same request is accepted and head x−1.
- Head x = 0 moving left, tick: head x = 127. Assert `game_over`, then 5 ticks: all outputs frozen. Reset: IDLE with reset values.
- 16 consecutive food steps: `score` saturates at 15, `ate` still pulses. Assert `victory`: HALT.

Source files
------------

// File: rtl/snake_body_pkg.sv
// Shared definitions for the snake movement stage: grid widths, segment
// count, direction and FSM encodings, and small combinational helpers.
package snake_body_pkg;

    localparam int X_W     = 7;
    localparam int Y_W     = 6;
    localparam int MAX_SEG = 15;

    localparam logic [3:0] SCORE_MAX = 4'd15;

    // Direction encodings as seen on dir_req.
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // FSM state codes.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HALT = 2'b10;

    // Up/down and left/right differ only in bit 0, so a reversal is an
    // xor of exactly 2'b01.
    function automatic logic is_reversal(input logic [1:0] a, input logic [1:0] b);
        return ((a ^ b) == 2'b01);
    endfunction

    // Next x coordinate for a direction; wraps modulo 2^X_W.
    function automatic logic [X_W-1:0] next_x(input logic [X_W-1:0] x, input logic [1:0] dir);
        logic [X_W-1:0] r;
        case (dir)
            DIR_LEFT:  r = x - 7'd1;
            DIR_RIGHT: r = x + 7'd1;
            default:   r = x;
        endcase
        return r;
    endfunction

    // Next y coordinate for a direction; wraps modulo 2^Y_W.
    function automatic logic [Y_W-1:0] next_y(input logic [Y_W-1:0] y, input logic [1:0] dir);
        logic [Y_W-1:0] r;
        case (dir)
            DIR_UP:   r = y - 6'd1;
            DIR_DOWN: r = y + 6'd1;
            default:  r = y;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snake_body_dir_ctrl.sv
// Direction control: holds the committed and pending directions and
// filters out reversals once the snake has a body.
import snake_body_pkg::*;

module snake_dir_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic       req_valid_i,
    input  logic [1:0] dir_req_i,
    input  logic       step_i,
    input  logic       rev_block_i,
    output logic [1:0] dir_pend_o
);

    logic [1:0] dir_cur_q;
    logic [1:0] dir_cur_d;
    logic [1:0] dir_pend_q;
    logic [1:0] dir_pend_d;
    logic       req_accept_s;

    // Next-direction logic; the reversal check looks at the committed
    // direction so two quick turns cannot fold the head onto its neck.
    always_comb begin
        dir_cur_d    = dir_cur_q;
        dir_pend_d   = dir_pend_q;
        req_accept_s = 1'b0;
        if (load_i) begin
            dir_cur_d  = dir_req_i;
            dir_pend_d = dir_req_i;
        end else begin
            if (step_i) begin
                dir_cur_d = dir_pend_q;
            end else begin
                dir_cur_d = dir_cur_q;
            end
            if (req_valid_i && !(rev_block_i && is_reversal(dir_req_i, dir_cur_q))) begin
                req_accept_s = 1'b1;
            end else begin
                req_accept_s = 1'b0;
            end
            if (req_accept_s) begin
                dir_pend_d = dir_req_i;
            end else begin
                dir_pend_d = dir_pend_q;
            end
        end
    end

    // Direction registers; reset heading is right.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_cur_q  <= DIR_RIGHT;
            dir_pend_q <= DIR_RIGHT;
        end else begin
            dir_cur_q  <= dir_cur_d;
            dir_pend_q <= dir_pend_d;
        end
    end

    assign dir_pend_o = dir_pend_q;

endmodule

// File: rtl/snake_body.sv
// Snake movement and body shift: steps the head on each accepted tick,
// shifts the 15-slot tail, detects food and tracks score. Freezes once
// the downstream checker reports game over or victory.
import snake_body_pkg::*;

module snake_body #(
    parameter logic [6:0] START_X = 7'd40,
    parameter logic [5:0] START_Y = 6'd30
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         move_tick,
    input  logic [1:0]   dir_req,
    input  logic         dir_valid,
    input  logic [6:0]   food_x,
    input  logic [5:0]   food_y,
    input  logic         game_over,
    input  logic         victory,
    output logic [6:0]   head_x,
    output logic [5:0]   head_y,
    output logic [104:0] tail_x,
    output logic [89:0]  tail_y,
    output logic [3:0]   score,
    output logic         ate
);

    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic [X_W-1:0]         head_x_q;
    logic [X_W-1:0]         head_x_d;
    logic [Y_W-1:0]         head_y_q;
    logic [Y_W-1:0]         head_y_d;
    logic [X_W*MAX_SEG-1:0] tail_x_q;
    logic [X_W*MAX_SEG-1:0] tail_x_d;
    logic [Y_W*MAX_SEG-1:0] tail_y_q;
    logic [Y_W*MAX_SEG-1:0] tail_y_d;
    logic [3:0]             score_q;
    logic [3:0]             score_d;
    logic                   ate_q;
    logic                   ate_d;

    logic                   halt_req_s;
    logic                   load_s;
    logic                   req_ok_s;
    logic                   step_s;
    logic                   rev_block_s;
    logic [1:0]             dir_pend_s;
    logic [X_W-1:0]         nxt_x_s;
    logic [Y_W-1:0]         nxt_y_s;
    logic                   hit_s;

    // Qualify ticks and direction requests against the current state.
    always_comb begin
        halt_req_s  = game_over | victory;
        load_s      = 1'b0;
        req_ok_s    = 1'b0;
        step_s      = 1'b0;
        rev_block_s = (score_q != 4'd0);
        case (state_q)
            ST_IDLE: begin
                load_s = dir_valid;
            end
            ST_RUN: begin
                if (!halt_req_s) begin
                    req_ok_s = dir_valid;
                    step_s   = move_tick;
                end else begin
                    req_ok_s = 1'b0;
                    step_s   = 1'b0;
                end
            end
            default: begin
                load_s   = 1'b0;
                req_ok_s = 1'b0;
                step_s   = 1'b0;
            end
        endcase
    end

    snake_dir_ctrl u_dir_ctrl (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load_s),
        .req_valid_i (req_ok_s),
        .dir_req_i   (dir_req),
        .step_i      (step_s),
        .rev_block_i (rev_block_s),
        .dir_pend_o  (dir_pend_s)
    );

    // Candidate head position and food hit for the pending direction.
    always_comb begin
        nxt_x_s = next_x(head_x_q, dir_pend_s);
        nxt_y_s = next_y(head_y_q, dir_pend_s);
        hit_s   = (nxt_x_s == food_x) && (nxt_y_s == food_y);
    end

    // FSM: IDLE waits for a first direction, RUN steps, HALT is sticky.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (dir_valid) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (halt_req_s) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // Datapath: a step always shifts; food only widens the valid window.
    always_comb begin
        head_x_d = head_x_q;
        head_y_d = head_y_q;
        tail_x_d = tail_x_q;
        tail_y_d = tail_y_q;
        score_d  = score_q;
        ate_d    = 1'b0;
        if (step_s) begin
            head_x_d = nxt_x_s;
            head_y_d = nxt_y_s;
            tail_x_d = {tail_x_q[X_W*(MAX_SEG-1)-1:0], head_x_q};
            tail_y_d = {tail_y_q[Y_W*(MAX_SEG-1)-1:0], head_y_q};
            if (hit_s) begin
                ate_d = 1'b1;
                if (score_q != SCORE_MAX) begin
                    score_d = score_q + 4'd1;
                end else begin
                    score_d = score_q;
                end
            end else begin
                ate_d   = 1'b0;
                score_d = score_q;
            end
        end else begin
            ate_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            head_x_q <= START_X;
            head_y_q <= START_Y;
            tail_x_q <= '0;
            tail_y_q <= '0;
            score_q  <= 4'd0;
            ate_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            head_x_q <= head_x_d;
            head_y_q <= head_y_d;
            tail_x_q <= tail_x_d;
            tail_y_q <= tail_y_d;
            score_q  <= score_d;
            ate_q    <= ate_d;
        end
    end

    assign head_x = head_x_q;
    assign head_y = head_y_q;
    assign tail_x = tail_x_q;
    assign tail_y = tail_y_q;
    assign score  = score_q;
    assign ate    = ate_q;

endmodule

// File: tb/tb_snake_body.sv
// Scoreboard bench for snake_body: a list-based reference model predicts
// each cycle's outputs, and a monitor compares them after every edge.
module tb_snake_body;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         move_tick = 1'b0;
    logic [1:0]   dir_req = 2'd0;
    logic         dir_valid = 1'b0;
    logic [6:0]   food_x = 7'd0;
    logic [5:0]   food_y = 6'd0;
    logic         game_over = 1'b0;
    logic         victory = 1'b0;
    logic [6:0]   head_x;
    logic [5:0]   head_y;
    logic [104:0] tail_x;
    logic [89:0]  tail_y;
    logic [3:0]   score;
    logic         ate;

    snake_body dut (
        .clk       (clk),
        .reset     (reset),
        .move_tick (move_tick),
        .dir_req   (dir_req),
        .dir_valid (dir_valid),
        .food_x    (food_x),
        .food_y    (food_y),
        .game_over (game_over),
        .victory   (victory),
        .head_x    (head_x),
        .head_y    (head_y),
        .tail_x    (tail_x),
        .tail_y    (tail_y),
        .score     (score),
        .ate       (ate)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]   hx;
        logic [5:0]   hy;
        logic [104:0] tx;
        logic [89:0]  ty;
        logic [3:0]   sc;
        logic         at;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   stim_done = 0;

    // Reference model: mode 0 waiting, 1 moving, 2 frozen.
    int m_mode, m_hx, m_hy, m_sc, m_cur, m_pend, m_ate;
    int m_tx[15];
    int m_ty[15];
    int g_fx = 100;
    int g_fy = 50;

    function automatic void dvec(input int d, output int dx, output int dy);
        dx = 0; dy = 0;
        if (d == 0) dy = -1;
        else if (d == 1) dy = 1;
        else if (d == 2) dx = -1;
        else dx = 1;
    endfunction

    task automatic model(input bit rst, input bit tick, input bit dv, input int req,
                         input int fx, input int fy, input bit go, input bit vic);
        int dx, dy, rx, ry, cx, cy, np;
        if (!rst) begin
            m_mode = 0; m_hx = 40; m_hy = 30; m_sc = 0; m_ate = 0;
            m_cur = 3; m_pend = 3;
            for (int i = 0; i < 15; i++) begin m_tx[i] = 0; m_ty[i] = 0; end
        end else begin
            m_ate = 0;
            if (m_mode == 0) begin
                if (dv) begin m_cur = req; m_pend = req; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (go || vic) begin
                    m_mode = 2;
                end else begin
                    np = m_pend;
                    dvec(req, rx, ry);
                    dvec(m_cur, cx, cy);
                    if (dv && !(m_sc >= 1 && rx == -cx && ry == -cy)) np = req;
                    if (tick) begin
                        dvec(m_pend, dx, dy);
                        for (int i = 14; i > 0; i--) begin m_tx[i] = m_tx[i-1]; m_ty[i] = m_ty[i-1]; end
                        m_tx[0] = m_hx; m_ty[0] = m_hy;
                        m_hx = (m_hx + dx + 128) % 128;
                        m_hy = (m_hy + dy + 64) % 64;
                        m_cur = m_pend;
                        if (m_hx == fx && m_hy == fy) begin
                            m_ate = 1;
                            if (m_sc < 15) m_sc++;
                        end
                    end
                    m_pend = np;
                end
            end
        end
    endtask

    // Drive one cycle of inputs and push the predicted post-edge outputs.
    task automatic drive(input bit rst, input bit tick, input bit dv, input int req,
                         input bit go, input bit vic);
        exp_t e;
        @(negedge clk);
        reset = rst; move_tick = tick; dir_valid = dv; dir_req = 2'(req);
        food_x = 7'(g_fx); food_y = 6'(g_fy); game_over = go; victory = vic;
        model(rst, tick, dv, req, g_fx, g_fy, go, vic);
        e.hx = 7'(m_hx); e.hy = 6'(m_hy); e.sc = 4'(m_sc); e.at = m_ate[0];
        for (int i = 0; i < 15; i++) begin
            e.tx[7*i +: 7] = 7'(m_tx[i]);
            e.ty[6*i +: 6] = 6'(m_ty[i]);
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // One move tick followed by two quiet cycles (divider period of 3).
    task automatic tick3();
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        idle(2);
    endtask

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Let the last driven cycle reach the outputs before a direct check.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge with a pending prediction is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total += 4;
                if (head_x !== e.hx || head_y !== e.hy) begin
                    bad++; $display("FAIL head: got (%0d,%0d) expected (%0d,%0d)", head_x, head_y, e.hx, e.hy);
                end
                if (tail_x !== e.tx || tail_y !== e.ty) begin
                    bad++; $display("FAIL tail: got x=%h y=%h expected x=%h y=%h", tail_x, tail_y, e.tx, e.ty);
                end
                if (score !== e.sc) begin
                    bad++; $display("FAIL score: got %0d expected %0d", score, e.sc);
                end
                if (ate !== e.at) begin
                    bad++; $display("FAIL ate: got %0d expected %0d", ate, e.at);
                end
            end
        end
    end

    initial begin
        int r, k;
        // Reset, then ticks while still waiting for a direction.
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        tick3(); tick3(); tick3();
        settle();
        chk("idle_head_x", head_x, 40);
        chk("idle_head_y", head_y, 30);
        chk("idle_score", score, 0);

        // Start moving right, three steps.
        drive(1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b0);
        tick3(); tick3(); tick3();
        settle();
        chk("run_head_x", head_x, 43);
        chk("run_tail0_x", tail_x[6:0], 42);
        chk("run_tail1_x", tail_x[13:7], 41);
        chk("run_tail2_x", tail_x[20:14], 40);
        chk("run_tail0_y", tail_y[5:0], 30);

        // Eat at (41,30), then again to reach score 2, then reject reversal.
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        g_fx = 41; g_fy = 30;
        drive(1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        settle();
        chk("eat_score", score, 1);
        chk("eat_ate", ate, 1);
        chk("eat_tail0_x", tail_x[6:0], 40);
        idle(2);
        g_fx = 42;
        tick3();
        drive(1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b0);
        tick3();
        settle();
        chk("reject_rev_x", head_x, 43);

        // Same reversal with an empty body is accepted.
        g_fx = 100; g_fy = 50;
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b0);
        tick3();
        settle();
        chk("accept_rev_x", head_x, 39);

        // Wrap from x=0 to 127, then freeze on game_over.
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b0);
        for (int i = 0; i < 41; i++) tick3();
        settle();
        chk("wrap_x", head_x, 127);
        drive(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick3();
        settle();
        chk("halt_x", head_x, 127);
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        settle();
        chk("rst_x", head_x, 40);
        chk("rst_score", score, 0);

        // Sixteen consecutive meals: score saturates, ate still pulses.
        drive(1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            g_fx = (m_hx + 1) % 128; g_fy = m_hy;
            tick3();
        end
        settle();
        chk("sat_score", score, 15);
        g_fx = 100; g_fy = 50;
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick3();

        // Randomized phase.
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        for (int n = 0; n < 4000; n++) begin
            k = $urandom_range(0, 7);
            if (k == 0) begin g_fx = (m_hx + 1) % 128; g_fy = m_hy; end
            else if (k == 1) begin g_fx = (m_hx + 127) % 128; g_fy = m_hy; end
            else if (k == 2) begin g_fx = m_hx; g_fy = (m_hy + 1) % 64; end
            else if (k == 3) begin g_fx = m_hx; g_fy = (m_hy + 63) % 64; end
            else begin g_fx = $urandom_range(0, 127); g_fy = $urandom_range(0, 63); end
            r = $urandom_range(0, 999);
            drive(r >= 3, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3), r >= 3 && r < 6, r >= 6 && r < 8);
        end

        settle();
        #20;
        chk("queue_drained", exp_q.size(), 0);
        stim_done = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #2000000;
        if (!stim_done) begin
            $display("FAIL timeout: got running expected finished");
            $fatal(1);
        end
    end

endmodule
